gemm_array_ctrl: RTL and testbench
==================================

GEMM_ARRAY_CTRL -- requirements
Module: gemm_array_ctrl

Interface
REQ-001 SHALL have parameter NumRows, default 4: PE rows in the output-stationary array.
REQ-002 SHALL have parameter NumCols, default 4: PE columns in the array.
REQ-003 SHALL have parameter KWidth, default 16: width of the reduction-length field.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: one-cycle request to run one tile.
REQ-007 SHALL have port k_len_i, input, KWidth: reduction length (operand beats), sampled with start_i.
REQ-008 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-009 SHALL have port in_valid_i, input, 1: edge operand source has a skewed A/B beat this cycle.
REQ-010 SHALL have port in_ready_o, output, 1: controller accepts a beat this cycle (FEED only).
REQ-011 SHALL have port a_valid_o, output, 1: broadcast to west-edge PE a_valid inputs.
REQ-012 SHALL have port b_valid_o, output, 1: broadcast to north-edge PE b_valid inputs.
REQ-013 SHALL have port acc_mux_sel_o, output, 2: broadcast to all PEs (00 accumulate, 01 flush north, 10 flush west, 11 clear).
REQ-014 SHALL have port out_valid_o, output, 1: south-edge PE accumulators hold a final result row.
REQ-015 SHALL have port out_row_o, output, $clog2(NumRows): row index of the result at the south edge.
REQ-016 SHALL have port done_o, output, 1: one-cycle pulse after the last row is presented.

Function
REQ-017 SHALL implement the FSM IDLE -> FEED -> DRAIN -> FLUSH -> DONE -> IDLE.
REQ-018 IDLE: acc_mux_sel_o=11 (hold clear); start_i moves to FEED, or to DRAIN if k_len_i==0; k_len_i latched.
REQ-019 FEED: acc_mux_sel_o=00; in_ready_o=1; a_valid_o=b_valid_o=in_valid_i.
REQ-020 FEED: beat counter increments on in_valid_i; FEED exits to DRAIN in the cycle after the beat that reaches k_len.
REQ-021 FEED: in_valid_i low is a bubble (zero operands, alignment preserved); no timeout.
REQ-022 DRAIN: acc_mux_sel_o=00; a_valid_o=b_valid_o=0; lasts exactly NumRows+NumCols-1 cycles, then FLUSH.
REQ-023 FLUSH: acc_mux_sel_o=01; lasts exactly NumRows cycles.
REQ-024 FLUSH: out_valid_o=1 in every cycle; out_row_o=NumRows-1-n in FLUSH cycle n (0-based).
REQ-025 DONE: done_o=1 for exactly one cycle; acc_mux_sel_o=11; returns to IDLE.
REQ-026 start_i outside IDLE SHALL be ignored; k_len latch unchanged.
REQ-027 in_valid_i outside FEED SHALL be ignored: a_valid_o=b_valid_o=0, in_ready_o=0.
REQ-028 All outputs SHALL be decoded combinationally from registered state and counters only (no input-to-output path except a/b_valid_o from in_valid_i in FEED).
REQ-029 Counters SHALL be sized for their maximum (k: KWidth; drain/flush: $clog2(NumRows+NumCols)) and never wrap; k_len=2^KWidth-1 is legal.
REQ-030 No backpressure on results: consumer SHALL accept every out_valid_o row.

Reset
REQ-031 rst_i high at a clock edge SHALL force IDLE and clear all counters and latches, from any state including mid-FEED/FLUSH.
REQ-032 Output values during and after reset SHALL be: busy_o=0, in_ready_o=0, a/b_valid_o=0, acc_mux_sel_o=11, out_valid_o=0, out_row_o=0, done_o=0.
REQ-033 rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-034 A shared package gemm_ctrl_pkg SHALL hold the FSM state enum and the acc_mux_sel encodings (ACC_ACCUM, ACC_FLUSH_N, ACC_FLUSH_W, ACC_CLEAR).
REQ-035 SHALL be a single module, no sub-module; the top-level array instantiates it once and fans out its outputs.

Verification (NumRows=NumCols=4)
REQ-036 Reset then start_i, k_len=3, in_valid_i held high -> FEED 3 cycles, DRAIN 7, FLUSH 4 with out_row 3,2,1,0, done_o 15 cycles after start_i edge.
REQ-037 k_len=3 with in_valid_i pattern 1,0,1,0,1 -> FEED lasts 5 cycles; a_valid_o mirrors in_valid_i; rest of timing as REQ-036.
REQ-038 k_len=0 -> no FEED, no in_ready_o; DRAIN 7, FLUSH 4, done_o.
REQ-039 start_i pulsed during DRAIN with k_len=9 -> ignored; completes with original k_len; no second run.
REQ-040 rst_i asserted in FLUSH cycle 2 -> next cycle IDLE, acc_mux_sel_o=11, out_valid_o=0, no done_o.
REQ-041 With a 4x4 general_mac_pe array, A=B=identity, k_len=4 -> south-edge rows match identity rows 3..0 on out_row 3..0.

Source files
------------

// File: rtl/gemm_ctrl_pkg.sv
// Shared types for the output-stationary GEMM array controller:
// FSM state encoding and the PE accumulator mux select codes.
package gemm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] ACC_ACCUM   = 2'b00;
    localparam logic [1:0] ACC_FLUSH_N = 2'b01;
    localparam logic [1:0] ACC_FLUSH_W = 2'b10;
    localparam logic [1:0] ACC_CLEAR   = 2'b11;

endpackage

// File: rtl/gemm_array_ctrl.sv
// Tile sequencer for an output-stationary PE array: feeds skewed operand
// beats, waits for the wavefront to drain, then flushes result rows south.
//
// state | meaning
// IDLE  | accumulators held clear, waiting for start_i
// FEED  | accepting k_len operand beats (bubbles allowed)
// DRAIN | last beats propagate across the skewed array
// FLUSH | one result row per cycle leaves the south edge, bottom row first
// DONE  | single-cycle completion pulse, accumulators cleared
module gemm_array_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter int NumRows = 4,
    parameter int NumCols = 4,
    parameter int KWidth  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [KWidth-1:0]          k_len_i,
    output logic                       busy_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       a_valid_o,
    output logic                       b_valid_o,
    output logic [1:0]                 acc_mux_sel_o,
    output logic                       out_valid_o,
    output logic [$clog2(NumRows)-1:0] out_row_o,
    output logic                       done_o
);

    localparam int CntW = $clog2(NumRows + NumCols);
    localparam int RowW = $clog2(NumRows);
    localparam logic [CntW-1:0] DrainLoad = CntW'(NumRows + NumCols - 2);
    localparam logic [CntW-1:0] FlushLoad = CntW'(NumRows - 1);

    state_e            state;
    state_e            state_next;
    logic [KWidth-1:0] k_len_q;
    logic [KWidth-1:0] k_cnt;
    logic [CntW-1:0]   tmr;
    logic              tmr_zero;
    logic              last_beat;

    assign tmr_zero  = (tmr == '0);
    // k_cnt never exceeds k_len_q, so the compare against k_len_q-1 cannot wrap in FEED
    assign last_beat = in_valid_i && (k_cnt == k_len_q - KWidth'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = (k_len_i == '0) ? ST_DRAIN : ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tmr_zero) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (tmr_zero) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Beat counter counts up to the latched length; the phase timer is a
    // down-counter reloaded on entry to DRAIN and FLUSH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_len_q <= '0;
            k_cnt   <= '0;
            tmr     <= '0;
        end else begin
            if (state == ST_IDLE && start_i) begin
                k_len_q <= k_len_i;
            end

            if (state == ST_FEED) begin
                if (in_valid_i) begin
                    k_cnt <= k_cnt + KWidth'(1);
                end
            end else begin
                k_cnt <= '0;
            end

            if (state_next == ST_DRAIN && state != ST_DRAIN) begin
                tmr <= DrainLoad;
            end else if (state_next == ST_FLUSH && state != ST_FLUSH) begin
                tmr <= FlushLoad;
            end else if (!tmr_zero) begin
                tmr <= tmr - CntW'(1);
            end
        end
    end

    always_comb begin
        busy_o        = (state != ST_IDLE);
        in_ready_o    = 1'b0;
        a_valid_o     = 1'b0;
        b_valid_o     = 1'b0;
        acc_mux_sel_o = ACC_CLEAR;
        out_valid_o   = 1'b0;
        out_row_o     = '0;
        done_o        = 1'b0;
        case (state)
            ST_FEED: begin
                acc_mux_sel_o = ACC_ACCUM;
                in_ready_o    = 1'b1;
                a_valid_o     = in_valid_i;
                b_valid_o     = in_valid_i;
            end
            ST_DRAIN: begin
                acc_mux_sel_o = ACC_ACCUM;
            end
            ST_FLUSH: begin
                acc_mux_sel_o = ACC_FLUSH_N;
                out_valid_o   = 1'b1;
                // timer counts NumRows-1 down to 0, which is the south-edge row index
                out_row_o     = tmr[RowW-1:0];
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                acc_mux_sel_o = ACC_CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_gemm_array_ctrl.sv
// Bench for gemm_array_ctrl: each tile's expected output timeline is derived
// from phase lengths (feed = position of k-th valid beat, drain, flush, done).
module tb_gemm_array_ctrl;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int KW = 16;
    localparam int D  = NR + NC - 1;
    localparam int R  = NR;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic                   a_valid;
    logic                   b_valid;
    logic [1:0]             acc_sel;
    logic                   out_valid;
    logic [$clog2(NR)-1:0]  out_row;
    logic                   done;

    int n_asserts = 0;
    int n_fail    = 0;

    gemm_array_ctrl #(.NumRows(NR), .NumCols(NC), .KWidth(KW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .k_len_i      (k_len),
        .busy_o       (busy),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_valid_o    (a_valid),
        .b_valid_o    (b_valid),
        .acc_mux_sel_o(acc_sel),
        .out_valid_o  (out_valid),
        .out_row_o    (out_row),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_busy, input logic e_rdy,
                                 input logic e_av, input logic [1:0] e_acc,
                                 input logic e_ov, input int e_row, input logic e_done);
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".a_valid"},   32'(a_valid),   32'(e_av));
        chk({tag, ".b_valid"},   32'(b_valid),   32'(e_av));
        chk({tag, ".acc_sel"},   32'(acc_sel),   32'(e_acc));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_row"},   32'(out_row),   e_row);
        chk({tag, ".done"},      32'(done),      32'(e_done));
    endtask

    task automatic check_idle(input string tag);
        check_outputs(tag, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b0);
    endtask

    // mode 0: in_valid always high; 1: alternating 1,0,1,...; 2: random.
    // rst_at >= 0 asserts reset (together with start) in that FLUSH cycle.
    task automatic run_tile(input int k, input int mode, input int rst_at);
        int   iv[$];
        int   ones;
        int   feed_len;
        int   total;
        int   n;
        bit   b;
        bit   e_feed, e_drain, e_flush, e_done;
        ones = 0;
        while (ones < k) begin
            if (mode == 0)      b = 1'b1;
            else if (mode == 1) b = (iv.size() % 2 == 0);
            else                b = 1'($urandom_range(0, 1));
            iv.push_back(int'(b));
            if (b) ones++;
        end
        feed_len = iv.size();
        total    = feed_len + D + R + 1;

        @(posedge clk); #1;
        start    = 1'b1;
        k_len    = KW'(k);
        in_valid = 1'($urandom_range(0, 1));
        #3;
        check_idle("idle_pre_start");

        for (int t = 0; t < total; t++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            k_len = KW'($urandom);
            if (t == feed_len) begin
                start = 1'b1;
                k_len = KW'(9);
            end
            in_valid = (t < feed_len) ? 1'(iv[t]) : 1'($urandom_range(0, 1));
            rst = (rst_at >= 0) && (t == feed_len + D + rst_at);
            if (rst) start = 1'b1;
            #3;
            e_feed  = (t < feed_len);
            e_drain = !e_feed && (t < feed_len + D);
            e_flush = !e_feed && !e_drain && (t < feed_len + D + R);
            e_done  = (t == total - 1);
            n       = t - feed_len - D;
            check_outputs($sformatf("tile_k%0d_t%0d", k, t), 1'b1, e_feed,
                          e_feed ? in_valid : 1'b0,
                          (e_feed || e_drain) ? 2'b00 : (e_flush ? 2'b01 : 2'b11),
                          e_flush, e_flush ? (R - 1 - n) : 0, e_done);
            if (rst) begin
                @(posedge clk); #1;
                start    = 1'b0;
                in_valid = 1'b1;
                #3;
                check_idle("after_flush_reset");
                rst = 1'b0;
                @(posedge clk); #1;
                #3;
                check_idle("reset_beats_start");
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        k_len    = KW'(5);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check_idle("in_reset");
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        #3;
        check_idle("post_reset");

        run_tile(3, 0, -1);
        run_tile(3, 1, -1);
        run_tile(0, 2, -1);
        run_tile(1, 0, -1);
        run_tile(5, 2, -1);
        run_tile(3, 0, 2);
        run_tile(2, 1, -1);
        for (int i = 0; i < 20; i++) begin
            run_tile($urandom_range(0, 12), $urandom_range(0, 2),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, R - 1) : -1);
        end

        @(posedge clk); #1;
        start = 1'b0;
        #3;
        check_idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
